logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered two-operand bitwise logic unit; successor to the fixed 1-bit ANDN/OR gate modules.
//  Eight selectable ops over W-bit operands, valid/ready stream in and out, 1-cycle latency.
//  Built-in sweep mode enumerates every {a,b} pair (the exhaustive table our gate benches print),
//  streams each result out and accumulates a total ones-count. Used standalone or as a self-check engine.
// PARAMETERS
//  W      1  operand/result width in bits; legal range 1..6 (sweep length 2^(2W))
//  CNT_W  derived (localparam) = 2*W + $clog2(W) + 1; width of sweep_ones, cannot overflow
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      operand beat valid
//  in_ready     out  1      unit accepts operand beat this cycle
//  in_a         in   W      operand a
//  in_b         in   W      operand b
//  in_op        in   3      op select for this beat
//  out_valid    out  1      result beat valid
//  out_ready    in   1      downstream accepts result
//  out_s        out  W      result
//  sweep_start  in   1      one-cycle request to start sweep
//  sweep_op     in   3      op used for whole sweep (sampled at start)
//  sweep_busy   out  1      sweep in progress
//  sweep_done   out  1      one-cycle pulse, sweep finished
//  sweep_ones   out  CNT_W  total 1-bits over all sweep results; held until next start
// BEHAVIOUR
//  Ops: 0 ANDN(~a&b) 1 OR 2 AND 3 XOR 4 NAND 5 NOR 6 XNOR 7 PASS_A; all bitwise, width W.
//  Reset (async on rst_n low): out_valid=0, out_s=0, sweep_busy=0, sweep_done=0, sweep_ones=0,
//   sweep counter=0, state IDLE. Release is synchronous to clk.
//  Output register: one stage. in_ready = !out_valid | out_ready (IDLE only).
//   Accepted beat -> out_s/out_valid valid next cycle (latency 1). out_s/out_valid held stable while
//   out_valid & !out_ready. Full throughput under continuous out_ready.
//  FSM: IDLE -> SWEEP on sweep_start when IDLE & !out_valid; else start ignored (no effect, no done).
//   SWEEP: in_ready=0; counter c (2W bits) gives a=c[2W-1:W], b=c[W-1:0]; issues one beat per cycle
//   in which output register may load; c increments per issued beat.
//   sweep_ones += popcount(result) at each issue. sweep_ones cleared to 0 on entering SWEEP.
//   After issuing c=all-ones -> DRAIN; DRAIN -> IDLE when last result accepted (out_valid&out_ready);
//   sweep_done=1 that same transition cycle +1 (registered pulse), sweep_busy=0 from IDLE.
//  Simultaneous: in_valid during SWEEP is not accepted; sweep_start during SWEEP/DRAIN ignored.
//  Counter wrap: c never wraps inside a sweep; reset to 0 on each start.
//  Reset mid-sweep: immediate abort to reset values; no sweep_done; in-flight result discarded.
//  No X propagation: out_s only changes on load; in_op/sweep_op values are all defined.
// STRUCTURE
//  Package logic_unit_pkg: op encodings (OP_ANDN..OP_PASSA), FSM state enum {IDLE,SWEEP,DRAIN},
//   function logic_eval(op,a,b) shared with the bench reference model.
//  One sub-module natural: popcount_w (W-bit popcount, combinational, $clog2(W)+1 out).
//  Top holds FSM, counter, output register, accumulator.
// TESTING
//  1 W=1, stream (a,b,op=0) 00,01,10,11 with out_ready=1 -> out_s 0,1,0,0 one cycle after each accept.
//  2 W=1 sweep_op=1(OR), out_ready=1 -> out_s 0,1,1,1; sweep_done pulse once; sweep_ones=3.
//  3 W=4 sweep_op=3(XOR), out_ready toggled 50% -> 256 results, none lost/duplicated; sweep_ones=512.
//  4 W=4 out_valid=1, out_ready=0 for 5 cycles -> out_s stable, in_ready=0; no beat accepted.
//  5 W=2 sweep_start while sweep_busy, and in_valid=1 during sweep -> ignored; in_ready=0; one done.
//  6 W=2 assert rst_n=0 at sweep beat 7 -> all outputs 0 asynchronously; no done; next sweep correct.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit: op encodings,
// sweep FSM states and the bit-level evaluation function.
package logic_unit_pkg;

    localparam int MAX_W = 6;

    typedef enum logic [2:0] {
        OP_ANDN  = 3'd0,
        OP_OR    = 3'd1,
        OP_AND   = 3'd2,
        OP_XOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Evaluated at full package width; callers truncate to their own W.
    function automatic logic [MAX_W-1:0] logic_eval(input logic [2:0] op,
                                                    input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b);
        case (op_e'(op))
            OP_ANDN: logic_eval = ~a & b;
            OP_OR:   logic_eval = a | b;
            OP_AND:  logic_eval = a & b;
            OP_XOR:  logic_eval = a ^ b;
            OP_NAND: logic_eval = ~(a & b);
            OP_NOR:  logic_eval = ~(a | b);
            OP_XNOR: logic_eval = ~(a ^ b);
            default: logic_eval = a;
        endcase
    endfunction

endpackage

// File: rtl/popcount_w.sv
// Combinational population count of a W-bit word.
module popcount_w #(
    parameter int W = 1
) (
    input  logic [W-1:0]         bits,
    output logic [$clog2(W):0]   count
);
    localparam int PW = $clog2(W) + 1;

    // NOTE: a combinational output gets a default before any conditional or
    // accumulating update, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered W-bit logic unit with valid/ready streams and a built-in
// exhaustive sweep mode that accumulates the ones-count of every result.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter  int W     = 1,
    localparam int CNT_W = 2 * W + $clog2(W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_s,
    input  logic             sweep_start,
    input  logic [2:0]       sweep_op,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [CNT_W-1:0] sweep_ones
);
    localparam int CW = 2 * W;
    localparam int PW = $clog2(W) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       sweep_op_q;
    logic             done_q;
    logic [CNT_W-1:0] ones_q;

    logic             load, in_fire, issue, last_issue, start, last_accept;
    logic [W-1:0]     in_s, issue_s;
    logic [PW-1:0]    issue_pop;

    assign in_s    = W'(logic_eval(in_op, MAX_W'(in_a), MAX_W'(in_b)));
    assign issue_s = W'(logic_eval(sweep_op_q, MAX_W'(cnt_q[CW-1:W]), MAX_W'(cnt_q[W-1:0])));

    popcount_w #(.W(W)) u_pop (
        .bits  (issue_s),
        .count (issue_pop)
    );

    // The output register may take a new beat whenever it is empty or being drained.
    assign load        = !out_valid || out_ready;
    assign in_ready    = (state_q == IDLE) && load;
    assign in_fire     = in_valid && in_ready;
    assign issue       = (state_q == SWEEP) && load;
    assign last_issue  = issue && (&cnt_q);
    assign start       = (state_q == IDLE) && sweep_start && !out_valid;
    assign last_accept = (state_q == DRAIN) && out_valid && out_ready;

    assign sweep_busy = (state_q != IDLE);
    assign sweep_done = done_q;
    assign sweep_ones = ones_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = SWEEP;
            SWEEP:   if (last_issue)  state_d = DRAIN;
            DRAIN:   if (last_accept) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sweep_op_q <= 3'd0;
            ones_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_accept;
            if (start) begin
                cnt_q      <= '0;
                ones_q     <= '0;
                sweep_op_q <= sweep_op;
            end else if (issue) begin
                ones_q <= ones_q + CNT_W'(issue_pop);
                if (!(&cnt_q)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= '0;
        end else if (in_fire || issue) begin
            out_valid <= 1'b1;
            out_s     <= issue ? issue_s : in_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
